// File: rtl/pc_sequencer.sv
// Program-counter sequencer: drives fetch PC, branch-LUT lookups and run/done status.
// Optional watchdog compiled in with `define SEQ_WATCHDOG_EN (forces DONE on counter saturation).
module pc_sequencer #(
  parameter int PC_W   = 8,
  parameter int WDOG_W = 12
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [1:0]      ProbSel,
  input  logic            Halt,
  input  logic            BrReq,
  input  logic            BrTaken,
  input  logic            BrLoop,
  input  logic [3:0]      BrIdx,
  input  logic [PC_W-1:0] Jump,
  output logic [1:0]      LutProblem,
  output logic            LutLoop,
  output logic [3:0]      LutJptrCon,
  output logic [2:0]      LutJptrB,
  output logic [PC_W-1:0] PC,
  output logic            Stall,
  output logic            Busy,
  output logic            Done,
  output logic            Err,
  output logic            Timeout
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REDIR, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      prob_q, prob_d;
  logic            loop_q, loop_d;
  logic [3:0]      con_q, con_d;
  logic [2:0]      lb_q, lb_d;
  logic            err_q, err_d;

  logic            idx_legal;
  logic            start_ok;
  logic            busy_w;
  logic            wdog_expire;
  logic [PC_W-1:0] pc_inc;

  assign busy_w   = (state_q == S_RUN) || (state_q == S_REDIR);
  assign start_ok = Start && (ProbSel != 2'd3) &&
                    ((state_q == S_IDLE) || (state_q == S_DONE));
  assign pc_inc   = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

  // Loop table is addressed by the low three index bits only.
  always_comb begin
    idx_legal = 1'b0;
    case (prob_q)
      2'd0:    idx_legal = BrLoop ? (BrIdx[2:0] <= 3'd3) : (BrIdx <= 4'd10);
      2'd1:    idx_legal = BrLoop ? 1'b1 : (BrIdx <= 4'd7);
      default: idx_legal = BrLoop ? 1'b1 : (BrIdx <= 4'd8);
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    prob_d  = prob_q;
    loop_d  = loop_q;
    con_d   = con_q;
    lb_d    = lb_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          if (ProbSel != 2'd3) begin
            prob_d  = ProbSel;
            pc_d    = '0;
            err_d   = 1'b0;
            state_d = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (wdog_expire) begin
          state_d = S_DONE;
        end else if (Halt) begin
          state_d = S_DONE;
        end else if (BrReq && BrTaken && idx_legal) begin
          loop_d  = BrLoop;
          con_d   = BrIdx;
          lb_d    = BrIdx[2:0];
          state_d = S_REDIR;
        end else begin
          pc_d = pc_inc;
          if (&pc_q) err_d = 1'b1;
          if (BrReq && BrTaken) err_d = 1'b1;
        end
      end
      S_REDIR: begin
        if (wdog_expire) begin
          state_d = S_DONE;
        end else begin
          pc_d    = Jump;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      prob_q  <= 2'd0;
      loop_q  <= 1'b0;
      con_q   <= 4'd0;
      lb_q    <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      prob_q  <= prob_d;
      loop_q  <= loop_d;
      con_q   <= con_d;
      lb_q    <= lb_d;
      err_q   <= err_d;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_q;
  logic              tmo_q;

  assign wdog_expire = busy_w && (&wdog_q);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wdog_q <= '0;
      tmo_q  <= 1'b0;
    end else if (start_ok) begin
      wdog_q <= '0;
      tmo_q  <= 1'b0;
    end else if (busy_w) begin
      wdog_q <= wdog_q + {{(WDOG_W-1){1'b0}}, 1'b1};
      if (&wdog_q) tmo_q <= 1'b1;
    end
  end

  assign Timeout = tmo_q;
`else
  assign wdog_expire = 1'b0;
  assign Timeout     = 1'b0;
`endif

  assign PC         = pc_q;
  assign LutProblem = prob_q;
  assign LutLoop    = loop_q;
  assign LutJptrCon = con_q;
  assign LutJptrB   = lb_q;
  assign Stall      = (state_q == S_REDIR);
  assign Busy       = busy_w;
  assign Done       = (state_q == S_DONE);
  assign Err        = err_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter controller that sequences instruction fetch for one of three problem programs and drives the branch-target lookup table. It sits between the instruction decoder, which raises branch/halt requests, and the branch LUT, which supplies 8-bit absolute jump targets. It owns the PC, the run/idle/done status of the core, and the one-cycle redirect bubble taken on every taken branch.

## Interface
Parameters:
- PC_W, 8, PC and jump-target width
- WDOG_W, 12, watchdog counter width (used only with watchdog compiled in)

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  one-cycle pulse; begins a program run when idle or done
- ProbSel  in  2  problem number latched on Start (0,1,2 legal)
- Halt  in  1  decoder: current instruction is halt
- BrReq  in  1  decoder: current instruction is a branch
- BrTaken  in  1  branch condition true (qualified by BrReq)
- BrLoop  in  1  1 = loop-branch table, 0 = conditional table
- BrIdx  in  4  table index; loop table uses BrIdx[2:0]
- Jump  in  PC_W  target returned by LUT (combinational on Lut* outputs)
- LutProblem  out  2  registered problem number to LUT
- LutLoop  out  1  registered table select to LUT
- LutJptrCon  out  4  registered conditional index to LUT
- LutJptrB  out  3  registered loop index to LUT
- PC  out  PC_W  current fetch address
- Stall  out  1  high during redirect cycle; decoder must ignore instruction
- Busy  out  1  high in RUN or REDIRECT
- Done  out  1  high in DONE
- Err  out  1  sticky error flag, cleared on Reset or legal Start
- Timeout  out  1  sticky watchdog flag (constant 0 when watchdog compiled out)

## Operation
- States: IDLE, RUN, REDIRECT, DONE.
- IDLE/DONE + Start: ProbSel 0–2 → latch into LutProblem, PC←0, clear Err/Timeout, go RUN. ProbSel=3 → set Err, state unchanged, PC unchanged.
- Start while Busy: ignored.
- RUN, priority per cycle: Halt > BrReq > sequential.
  - Halt: go DONE, PC holds (points at halt).
  - BrReq & BrTaken & legal index: register LutLoop=BrLoop, LutJptrCon=BrIdx, LutJptrB=BrIdx[2:0]; go REDIRECT; PC holds.
  - BrReq & BrTaken & illegal index: set Err, PC←PC+1, stay RUN.
  - BrReq & !BrTaken: PC←PC+1.
  - otherwise PC←PC+1.
- Legal indices: problem 0 loop 0–3, conditional 0–10; problem 1 loop 0–7, conditional 0–7; problem 2 loop 0–7, conditional 0–8.
- REDIRECT: PC←Jump, return to RUN. Halt/BrReq ignored this cycle.
- PC increment is modulo 2^PC_W; wrap from all-ones to 0 sets Err and continues.
- DONE holds PC and Done until Start or Reset.

## Timing
- Reset values: state IDLE, PC=0, LutProblem=0, LutLoop=0, LutJptrCon=0, LutJptrB=0, Stall=0, Busy=0, Done=0, Err=0, Timeout=0.
- Start→Busy: 1 cycle; first fetch PC=0 in cycle after Start.
- Taken branch: 2-cycle latency; cycle N branch seen, cycle N+1 Stall=1 with Lut* valid, cycle N+2 PC=Jump.
- Stall, Busy, Done are decoded from registered state (no combinational path from inputs).
- Reset during REDIRECT or RUN wins over all inputs; redirect is discarded.

## Configuration
- SEQ_WATCHDOG_EN defined: WDOG_W-bit counter cleared on Start, increments each cycle in RUN/REDIRECT; on reaching all-ones it sets Timeout and forces DONE next cycle (overrides Halt/branch).
- Not defined: no counter, Timeout tied 0, run continues indefinitely.

## Test plan
- Reset, Start ProbSel=1, no branches for 5 cycles → PC 0,1,2,3,4; Busy=1, Stall=0.
- Problem 0, at PC=6 BrReq=1 BrTaken=1 BrLoop=0 BrIdx=9, Jump model returns 70 → next cycle Stall=1, LutJptrCon=9; following cycle PC=70.
- Problem 1, BrReq & BrTaken BrLoop=0 BrIdx=8 at PC=20 → no redirect, Err=1, PC=21 next cycle.
- Halt and BrReq/BrTaken same cycle at PC=40 → DONE, Done=1, PC stays 40; Start ProbSel=2 → Err cleared, PC=0.
- Start ProbSel=3 from IDLE → Err=1, stays IDLE; Reset asserted during REDIRECT → IDLE, PC=0, Stall=0.
- With SEQ_WATCHDOG_EN, WDOG_W=4, no Halt → Timeout=1 and Done=1 at 16th cycle after Start; without it, Busy stays 1.
